// File: rtl/freq_mac.sv
// Frequency-domain complex MAC: multiplies each FFT tile by a stored kernel spectrum and accumulates over INCHNL channels.
// Optional per-component saturation of the accumulator and output sums is enabled by defining FREQ_MAC_SAT_EN.
module freq_mac #(
  parameter int DATALEN = 16,
  parameter int FFTCHNL = 8,
  parameter int BEATS   = 4,
  parameter int INCHNL  = 16,
  parameter int FRAC    = 14,
  parameter int ACCLEN  = 40,
  localparam int NLANE  = 2*FFTCHNL,
  localparam int DEPTH  = BEATS*INCHNL,
  localparam int AW     = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int IW     = NLANE*2*DATALEN,
  localparam int OW     = NLANE*2*ACCLEN
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          clr,
  input  logic          invalid,
  input  logic [IW-1:0] indata,
  input  logic          kwen,
  input  logic [AW-1:0] kwaddr,
  input  logic [IW-1:0] kwdata,
  output logic          outvalid,
  output logic [OW-1:0] outdata,
  output logic          busy
);
  localparam int BW = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int CW = (INCHNL > 1) ? $clog2(INCHNL) : 1;
  localparam int PW = 2*DATALEN+1;

  function automatic logic signed [ACCLEN-1:0] scale(input logic signed [PW-1:0] p);
    logic signed [PW-1:0] s;
    s = p >>> FRAC;
    return ACCLEN'(s);
  endfunction

  function automatic logic [2*ACCLEN-1:0] cmul(input logic [2*DATALEN-1:0] x,
                                               input logic [2*DATALEN-1:0] w);
    logic signed [PW-1:0] a, b, c, d, pr, pi;
    a  = PW'(signed'(x[DATALEN-1:0]));
    b  = PW'(signed'(x[2*DATALEN-1:DATALEN]));
    c  = PW'(signed'(w[DATALEN-1:0]));
    d  = PW'(signed'(w[2*DATALEN-1:DATALEN]));
    pr = a*c - b*d;
    pi = a*d + b*c;
    return {scale(pi), scale(pr)};
  endfunction

  function automatic logic signed [ACCLEN-1:0] acc_add(input logic signed [ACCLEN-1:0] x,
                                                       input logic signed [ACCLEN-1:0] y);
    logic signed [ACCLEN-1:0] r;
`ifdef FREQ_MAC_SAT_EN
    logic signed [ACCLEN:0] s;
    s = {x[ACCLEN-1], x} + {y[ACCLEN-1], y};
    r = s[ACCLEN-1:0];
    if (s[ACCLEN] != s[ACCLEN-1])
      r = s[ACCLEN] ? {1'b1, {(ACCLEN-1){1'b0}}} : {1'b0, {(ACCLEN-1){1'b1}}};
`else
    r = x + y;
`endif
    return r;
  endfunction

  logic [IW-1:0] r_kram [DEPTH];
  logic [BW-1:0] r_beatcnt;
  logic [CW-1:0] r_chcnt;
  logic [AW-1:0] w_raddr;
  logic          r_vld_p1, r_first_p1, r_last_p1;
  logic [BW-1:0] r_beat_p1;
  logic [IW-1:0] r_in_p1, r_kw_p1;
  logic          r_vld_p2, r_first_p2, r_last_p2;
  logic [BW-1:0] r_beat_p2;
  logic [OW-1:0] r_prod_p2;
  logic [OW-1:0] r_acc [BEATS];
  logic [OW-1:0] w_base, w_sum;
  logic          w_emit;

  assign w_raddr = AW'(r_chcnt) * AW'(BEATS) + AW'(r_beatcnt);
  assign busy    = (r_chcnt != '0) || (r_beatcnt != '0);
  assign w_emit  = r_vld_p2 & r_last_p2 & ~clr;

  always_ff @(posedge clk) begin
    if (kwen)
      r_kram[kwaddr] <= kwdata;
  end

  // S1: capture the beat, its kernel word and its position tags
  always_ff @(posedge clk) begin
    if (invalid) begin
      r_in_p1    <= indata;
      r_kw_p1    <= r_kram[w_raddr];
      r_beat_p1  <= r_beatcnt;
      r_first_p1 <= (r_chcnt == '0);
      r_last_p1  <= (r_chcnt == CW'(INCHNL-1));
    end
  end

  // S2: per-lane complex products, scaled back to accumulator width
  always_ff @(posedge clk) begin
    if (r_vld_p1) begin
      for (int k = 0; k < NLANE; k++)
        r_prod_p2[k*2*ACCLEN +: 2*ACCLEN] <= cmul(r_in_p1[k*2*DATALEN +: 2*DATALEN],
                                                  r_kw_p1[k*2*DATALEN +: 2*DATALEN]);
      r_beat_p2  <= r_beat_p1;
      r_first_p2 <= r_first_p1;
      r_last_p2  <= r_last_p1;
    end
  end

  // S3: accumulate; the first channel starts from zero, the last channel goes out instead of back
  always_comb begin
    w_base = r_first_p2 ? '0 : r_acc[r_beat_p2];
    w_sum  = '0;
    for (int k = 0; k < NLANE; k++) begin
      w_sum[k*2*ACCLEN +: ACCLEN] = acc_add(w_base[k*2*ACCLEN +: ACCLEN],
                                            r_prod_p2[k*2*ACCLEN +: ACCLEN]);
      w_sum[k*2*ACCLEN+ACCLEN +: ACCLEN] = acc_add(w_base[k*2*ACCLEN+ACCLEN +: ACCLEN],
                                                   r_prod_p2[k*2*ACCLEN+ACCLEN +: ACCLEN]);
    end
  end

  always_ff @(posedge clk) begin
    if (r_vld_p2 && !r_last_p2 && !clr)
      r_acc[r_beat_p2] <= w_sum;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_beatcnt <= '0;
      r_chcnt   <= '0;
      r_vld_p1  <= 1'b0;
      r_vld_p2  <= 1'b0;
      outvalid  <= 1'b0;
      outdata   <= '0;
    end else begin
      outvalid <= w_emit;
      if (w_emit)
        outdata <= w_sum;
      if (clr) begin
        r_beatcnt <= '0;
        r_chcnt   <= '0;
        r_vld_p1  <= 1'b0;
        r_vld_p2  <= 1'b0;
      end else begin
        r_vld_p1 <= invalid;
        r_vld_p2 <= r_vld_p1;
        if (invalid) begin
          if (r_beatcnt == BW'(BEATS-1)) begin
            r_beatcnt <= '0;
            r_chcnt   <= (r_chcnt == CW'(INCHNL-1)) ? '0 : r_chcnt + CW'(1);
          end else begin
            r_beatcnt <= r_beatcnt + BW'(1);
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_freq_mac.sv
// Bench for freq_mac: arithmetic model with an output queue, plus literal checks including a single-channel instance.
module tb_freq_mac;
  localparam int DL = 16;
  localparam int NL = 16;
  localparam int BT = 4;
  localparam int IC = 16;
  localparam int FR = 14;
  localparam int AL = 20;
  localparam int AL1 = 40;
  localparam int IW = NL*2*DL;
  localparam int OW = NL*2*AL;
  localparam int OW1 = NL*2*AL1;
  localparam int DEPTH = BT*IC;
  localparam int AW = $clog2(DEPTH);
  localparam int AW1 = $clog2(BT);

  logic clk = 1'b0;
  logic rstn = 1'b1;
  logic clr = 1'b0, invalid = 1'b0, kwen = 1'b0;
  logic [IW-1:0] indata = '0, kwdata = '0;
  logic [AW-1:0] kwaddr = '0;
  logic outvalid, busy;
  logic [OW-1:0] outdata;

  logic d1_clr = 1'b0, d1_invalid = 1'b0, d1_kwen = 1'b0;
  logic [IW-1:0] d1_indata = '0, d1_kwdata = '0;
  logic [AW1-1:0] d1_kwaddr = '0;
  logic d1_outvalid, d1_busy;
  logic [OW1-1:0] d1_outdata;

  int vectors = 0;
  int errors = 0;

  freq_mac #(.DATALEN(DL), .FFTCHNL(NL/2), .BEATS(BT), .INCHNL(IC), .FRAC(FR), .ACCLEN(AL)) dut (
    .clk(clk), .rstn(rstn), .clr(clr), .invalid(invalid), .indata(indata),
    .kwen(kwen), .kwaddr(kwaddr), .kwdata(kwdata),
    .outvalid(outvalid), .outdata(outdata), .busy(busy));

  freq_mac #(.DATALEN(DL), .FFTCHNL(NL/2), .BEATS(BT), .INCHNL(1), .FRAC(FR), .ACCLEN(AL1)) dut1 (
    .clk(clk), .rstn(rstn), .clr(d1_clr), .invalid(d1_invalid), .indata(d1_indata),
    .kwen(d1_kwen), .kwaddr(d1_kwaddr), .kwdata(d1_kwdata),
    .outvalid(d1_outvalid), .outdata(d1_outdata), .busy(d1_busy));

  always #5 clk = ~clk;

  // model state
  longint kre [DEPTH][NL];
  longint kim [DEPTH][NL];
  longint acc_re [BT][NL];
  longint acc_im [BT][NL];
  int nacc = 0;
  longint ecount = 0;
  logic [OW-1:0] exp_q[$];
  longint due_q[$];
  logic lit_en = 1'b0;
  logic [OW-1:0] lit_vec = '0;
  int lit_seen = 0;

  function automatic longint sx16(input logic [DL-1:0] v);
    return longint'(signed'(v));
  endfunction

  function automatic longint fit(input longint v);
    longint hi, lo, m;
    hi = (longint'(1) <<< (AL-1)) - 1;
    lo = -(longint'(1) <<< (AL-1));
`ifdef FREQ_MAC_SAT_EN
    m = (v > hi) ? hi : ((v < lo) ? lo : v);
`else
    m = v & ((longint'(1) <<< AL) - 1);
    if (m > hi) m = m - (longint'(1) <<< AL);
`endif
    return m;
  endfunction

  function automatic logic [IW-1:0] pack(input int re, input int im);
    logic [IW-1:0] v;
    for (int k = 0; k < NL; k++) v[k*2*DL +: 2*DL] = {DL'(im), DL'(re)};
    return v;
  endfunction

  function automatic logic [IW-1:0] rand_word(input int mag);
    logic [IW-1:0] v;
    int re, im;
    for (int k = 0; k < NL; k++) begin
      re = int'($urandom_range(0, 2*mag)) - mag;
      im = int'($urandom_range(0, 2*mag)) - mag;
      v[k*2*DL +: 2*DL] = {DL'(im), DL'(re)};
    end
    return v;
  endfunction

  function automatic logic [OW-1:0] lit_out(input longint re, input longint im);
    logic [OW-1:0] v;
    for (int k = 0; k < NL; k++) v[k*2*AL +: 2*AL] = {AL'(im), AL'(re)};
    return v;
  endfunction

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic chk_out(input string nm, input logic [OW-1:0] act, input logic [OW-1:0] exp);
    int bad;
    bad = -1;
    vectors++;
    for (int k = 0; k < NL; k++)
      if (bad < 0 && act[k*2*AL +: 2*AL] !== exp[k*2*AL +: 2*AL]) bad = k;
    if (bad >= 0) begin
      errors++;
      $display("FAIL %s lane %0d: got %h expected %h at %0t", nm, bad,
               act[bad*2*AL +: 2*AL], exp[bad*2*AL +: 2*AL], $time);
    end
  endtask

  task automatic model_beat();
    int ch, bt;
    longint a, b, c, d, pr, pi, sr, si;
    logic [OW-1:0] ov;
    ch = nacc / BT;
    bt = nacc % BT;
    ov = '0;
    for (int k = 0; k < NL; k++) begin
      a  = sx16(indata[k*2*DL +: DL]);
      b  = sx16(indata[k*2*DL+DL +: DL]);
      c  = kre[nacc][k];
      d  = kim[nacc][k];
      pr = (a*c - b*d) >>> FR;
      pi = (a*d + b*c) >>> FR;
      sr = (ch == 0) ? fit(pr) : fit(acc_re[bt][k] + pr);
      si = (ch == 0) ? fit(pi) : fit(acc_im[bt][k] + pi);
      if (ch == IC-1) ov[k*2*AL +: 2*AL] = {AL'(si), AL'(sr)};
      else begin
        acc_re[bt][k] = sr;
        acc_im[bt][k] = si;
      end
    end
    if (ch == IC-1) begin
      exp_q.push_back(ov);
      due_q.push_back(ecount + 2);
    end
    nacc = (nacc + 1) % DEPTH;
  endtask

  initial forever begin
    @(posedge clk or negedge rstn);
    if (!rstn) begin
      nacc = 0;
      exp_q.delete();
      due_q.delete();
    end else begin
      ecount++;
      if (clr) begin
        nacc = 0;
        exp_q.delete();
        due_q.delete();
      end else if (invalid) begin
        model_beat();
      end
    end
  end

  initial begin
    logic ev;
    forever begin
      @(negedge clk);
      if (!rstn) begin
        chk("reset_outvalid", outvalid, 0);
        chk("reset_busy", busy, 0);
        chk_out("reset_outdata", outdata, '0);
      end else begin
        ev = (due_q.size() > 0) && (due_q[0] == ecount);
        chk("outvalid", outvalid, ev);
        chk("busy", busy, nacc != 0);
        if (ev) begin
          if (outvalid) chk_out("outdata", outdata, exp_q[0]);
          void'(exp_q.pop_front());
          void'(due_q.pop_front());
        end
        if (lit_en && outvalid) begin
          lit_seen++;
          chk_out("literal_out", outdata, lit_vec);
        end
      end
    end
  end

  task automatic kw_write(input int a, input logic [IW-1:0] w);
    kwen = 1'b1;
    kwaddr = AW'(a);
    kwdata = w;
    for (int k = 0; k < NL; k++) begin
      kre[a][k] = sx16(w[k*2*DL +: DL]);
      kim[a][k] = sx16(w[k*2*DL+DL +: DL]);
    end
    @(posedge clk); #1;
    kwen = 1'b0;
  endtask

  task automatic send(input logic [IW-1:0] d, input int gap);
    invalid = 1'b1;
    indata = d;
    @(posedge clk); #1;
    invalid = 1'b0;
    repeat (gap) begin @(posedge clk); #1; end
  endtask

  task automatic run_rand(input int n, input int mag, input int maxgap);
    for (int i = 0; i < n; i++) send(rand_word(mag), int'($urandom_range(0, maxgap)));
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  initial begin
    logic [OW1-1:0] e1;
    #1 rstn = 1'b0;
    repeat (3) @(posedge clk);
    #1 rstn = 1'b1;
    idle(1);

    // unit kernel, constant input, 16 channels
    for (int a = 0; a < DEPTH; a++) kw_write(a, pack(16384, 0));
    lit_vec = lit_out(1600, -800);
    lit_en = 1'b1;
    lit_seen = 0;
    for (int i = 0; i < DEPTH; i++) send(pack(100, -50), 0);
    idle(6);
    lit_en = 1'b0;
    chk("unit_kernel_pulses", lit_seen, 4);

    // single-channel instance: multiply by j, latency 3
    for (int a = 0; a < BT; a++) begin
      d1_kwen = 1'b1;
      d1_kwaddr = AW1'(a);
      d1_kwdata = pack(0, 16384);
      @(posedge clk); #1;
    end
    d1_kwen = 1'b0;
    for (int k = 0; k < NL; k++) e1[k*2*AL1 +: 2*AL1] = {AL1'(3), AL1'(-4)};
    d1_indata = pack(3, 4);
    d1_invalid = 1'b1;
    for (int i = 1; i <= 7; i++) begin
      @(posedge clk); #1;
      if (i == 4) d1_invalid = 1'b0;
      #3;
      chk($sformatf("d1_outvalid_c%0d", i), d1_outvalid, (i >= 3 && i <= 6));
      if (i >= 3 && i <= 6)
        for (int k = 0; k < NL; k++)
          chk("d1_outdata_lane", d1_outdata[k*2*AL1 +: 2*AL1], e1[k*2*AL1 +: 2*AL1]);
      if (i == 2) chk("d1_busy_mid", d1_busy, 1);
      if (i == 7) chk("d1_busy_end", d1_busy, 0);
    end
    #1;

    // random kernels and inputs with gaps, two channel sets
    for (int a = 0; a < DEPTH; a++) kw_write(a, rand_word(32767));
    run_rand(2*DEPTH, 4095, 5);
    idle(8);
    chk("busy_after_sets", busy, 0);

    // clr mid channel 7 with a beat on the same cycle, then a clean set
    run_rand(30, 4095, 1);
    clr = 1'b1;
    invalid = 1'b1;
    indata = rand_word(4095);
    @(posedge clk); #1;
    clr = 1'b0;
    invalid = 1'b0;
    chk("busy_after_clr", busy, 0);
    run_rand(DEPTH, 4095, 2);
    idle(8);

    // max-magnitude products overflow a 20-bit accumulator
    for (int a = 0; a < DEPTH; a++) kw_write(a, pack(-32768, 32767));
`ifdef FREQ_MAC_SAT_EN
    lit_vec = lit_out(524287, -524288);
`else
    lit_vec = lit_out(0, 32);
`endif
    lit_en = 1'b1;
    lit_seen = 0;
    for (int i = 0; i < DEPTH; i++) send(pack(-32768, 0), 0);
    idle(6);
    lit_en = 1'b0;
    chk("overflow_pulses", lit_seen, 4);

    // reset in the middle of a tile, then a full tile
    for (int a = 0; a < DEPTH; a++) kw_write(a, rand_word(32767));
    run_rand(30, 4095, 0);
    rstn = 1'b0;
    #1;
    chk("midreset_outvalid", outvalid, 0);
    chk("midreset_busy", busy, 0);
    chk_out("midreset_outdata", outdata, '0);
    idle(2);
    rstn = 1'b1;
    idle(1);
    run_rand(DEPTH, 4095, 1);
    idle(8);
    chk("final_queue_empty", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

endmodule
